// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: shared vector-ALU types, flag bit positions and Q7.8 limits
package vec_alu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG = 2;
    localparam int FLAG_OVF = 3;
    localparam int Q_FRAC = 8;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;
endpackage

// File: rtl/alu_vec_fxp_div_if.sv
// alu_vec_fxp_div_if: start/done request bus of the fixed-point divider
interface alu_vec_fxp_div_if #(parameter int WIDTH = 16);
    logic start;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic busy;
    logic done;
    logic [WIDTH-1:0] result;
    logic [3:0] flags;
    logic div_zero;
    modport master(output start, data_a, data_b, input busy, done, result, flags, div_zero);
    modport slave(input start, data_a, data_b, output busy, done, result, flags, div_zero);
endinterface

// File: rtl/alu_vec_fxp_div_two_complement.sv
// two_complement: unsigned magnitude of a two's complement value (|min| stays min)
module two_complement #(parameter int N = 16) (
    input  logic [N-1:0] value,
    output logic [N-1:0] magnitude
);
    assign magnitude = value[N-1] ? -value : value;
endmodule

// File: rtl/alu_vec_fxp_div.sv
// alu_vec_fxp_div: sequential signed Q7.8 restoring divider with lane-ALU flags
module alu_vec_fxp_div
    import vec_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC = Q_FRAC
) (
    input logic clk,
    input logic rst,
    alu_vec_fxp_div_if.slave bus
);
    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW);
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] rem, rem_sh;
    logic [QW-1:0] dvd, q, q_next;
    logic [WIDTH-1:0] mag_a, mag_b_in, mag_b, res, result;
    logic [3:0] flg, flags;
    logic neg, dz, ge, sat_p, sat_n, busy, done, div_zero;

    two_complement #(.N(WIDTH)) u_abs_a (.value(bus.data_a), .magnitude(mag_a));
    two_complement #(.N(WIDTH)) u_abs_b (.value(bus.data_b), .magnitude(mag_b_in));

    // One restoring step, plus saturation/flags on the quotient that step completes
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], dvd[QW-1]};
        ge = rem_sh >= {1'b0, mag_b};
        q_next = {q[QW-2:0], ge};
        sat_p = !neg && q_next > QW'(Q_MAX);
        sat_n = neg && q_next > QW'(Q_MIN);
        res = dz ? (neg ? Q_MIN : Q_MAX) : sat_p ? Q_MAX : sat_n ? Q_MIN :
              neg ? -q_next[WIDTH-1:0] : q_next[WIDTH-1:0];
        flg = '0;
        flg[FLAG_OVF] = dz | sat_p | sat_n;
        flg[FLAG_NEG] = res[WIDTH-1];
        flg[FLAG_ZERO] = res == '0;
    end

    // Control FSM and datapath; the result is captured on the last iteration so done lines up with DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rem <= '0;
            dvd <= '0;
            q <= '0;
            mag_b <= '0;
            neg <= 1'b0;
            dz <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            flags <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= CALC;
                    busy <= 1'b1;
                    mag_b <= mag_b_in;
                    neg <= bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
                    dz <= bus.data_b == '0;
                    rem <= '0;
                    dvd <= {mag_a, {FRAC{1'b0}}};
                    cnt <= '0;
                end
                CALC: begin
                    rem <= ge ? rem_sh - {1'b0, mag_b} : rem_sh;
                    dvd <= dvd << 1;
                    q <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(QW - 1)) begin
                        state <= DONE;
                        cnt <= '0;
                        done <= 1'b1;
                        result <= res;
                        flags <= flg;
                        div_zero <= dz;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.result = result;
    assign bus.flags = flags;
    assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_alu_vec_fxp_div.sv
// tb_alu_vec_fxp_div: directed, random, abort and back-to-back checks of the divider
module tb_alu_vec_fxp_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_vec_fxp_div_if bus ();
    alu_vec_fxp_div dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: signed real-valued division scaled by 256, truncated, then clamped
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f, output logic z);
        int sa, sb, ma, mb;
        longint q;
        logic ng, ovf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = sa < 0 ? -sa : sa;
        mb = sb < 0 ? -sb : sb;
        ng = (sa < 0) != (sb < 0);
        z = sb == 0;
        ovf = 1'b1;
        if (z) r = sa < 0 ? 16'h8000 : 16'h7FFF;
        else begin
            q = longint'(ma) * 256 / mb;
            if (!ng && q > 32767) r = 16'h7FFF;
            else if (ng && q > 32768) r = 16'h8000;
            else begin
                r = ng ? 16'(-q) : 16'(q);
                ovf = 1'b0;
            end
        end
        f = {ovf, r[15], r == 16'h0, 1'b0};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_a = a;
        bus.data_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_a = 16'($urandom);
        bus.data_b = 16'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", bus.result); end
        if (bus.flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] ta [10] = '{16'h0300, 16'hFE80, 16'h0100, 16'h0000, 16'h0100,
                                 16'hFF00, 16'h7F00, 16'h8000, 16'h8000, 16'h0000};
        logic [15:0] tb [10] = '{16'h0200, 16'h0080, 16'h0300, 16'h0300, 16'h0000,
                                 16'h0000, 16'h0001, 16'h0100, 16'hFF00, 16'hFF00};
        logic [15:0] tr [10] = '{16'h0180, 16'hFD00, 16'h0055, 16'h0000, 16'h7FFF,
                                 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
        logic [3:0] tf [10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b1000,
                                4'b1100, 4'b1000, 4'b0100, 4'b1000, 4'b0010};
        logic tz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 10; i++) begin
            do_op(ta[i], tb[i], lat);
            checks += 4;
            if (lat !== 25) begin errors++; $display("FAIL dir%0d_latency: got %0d want 25", i, lat); end
            if (bus.result !== tr[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, bus.result, tr[i]); end
            if (bus.flags !== tf[i]) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, bus.flags, tf[i]); end
            if (bus.div_zero !== tz[i]) begin errors++; $display("FAIL dir%0d_dz: got %b want %b", i, bus.div_zero, tz[i]); end
        end
        repeat (3) @(negedge clk);
        checks += 3;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", bus.busy); end
        if (bus.result !== tr[9]) begin errors++; $display("FAIL hold_result: got %h want %h", bus.result, tr[9]); end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r;
        logic [3:0] f;
        logic z;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 15));
                1: b = 16'h0000;
                default: b = 16'($urandom);
            endcase
            model(a, b, r, f, z);
            do_op(a, b, lat);
            checks += 4;
            if (lat !== 25) begin errors++; $display("FAIL rnd_latency %h/%h: got %0d want 25", a, b, lat); end
            if (bus.result !== r) begin errors++; $display("FAIL rnd_result %h/%h: got %h want %h", a, b, bus.result, r); end
            if (bus.flags !== f) begin errors++; $display("FAIL rnd_flags %h/%h: got %b want %b", a, b, bus.flags, f); end
            if (bus.div_zero !== z) begin errors++; $display("FAIL rnd_dz %h/%h: got %b want %b", a, b, bus.div_zero, z); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_a = 16'h0300;
        bus.data_b = 16'h0200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
        if (bus.result !== 16'h0) begin errors++; $display("FAIL abort_result: got %h want 0000", bus.result); end
        if (bus.flags !== 4'h0) begin errors++; $display("FAIL abort_flags: got %b want 0000", bus.flags); end
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        do_op(16'h0300, 16'h0200, lat);
        checks += 2;
        if (lat !== 25) begin errors++; $display("FAIL restart_latency: got %0d want 25", lat); end
        if (bus.result !== 16'h0180) begin errors++; $display("FAIL restart_result: got %h want 0180", bus.result); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] da [80];
        logic [15:0] db [80];
        logic [15:0] r;
        logic [3:0] f;
        logic z;
        int dcyc [$];
        int idx;
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            if (i > 0 && bus.done === 1'b1) begin
                dcyc.push_back(i);
                idx = i >= 25 ? i - 25 : 0;
                model(da[idx], db[idx], r, f, z);
                checks += 2;
                if (bus.result !== r) begin errors++; $display("FAIL b2b_result@%0d: got %h want %h", i, bus.result, r); end
                if (bus.flags !== f) begin errors++; $display("FAIL b2b_flags@%0d: got %b want %b", i, bus.flags, f); end
            end
            if (i < 78) begin
                da[i] = 16'($urandom);
                db[i] = 16'($urandom_range(1, 2047));
                bus.start = 1'b1;
                bus.data_a = da[i];
                bus.data_b = db[i];
            end else bus.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dcyc.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dcyc.size()); end
        else begin
            checks += 3;
            if (dcyc[0] !== 25) begin errors++; $display("FAIL b2b_done0: got %0d want 25", dcyc[0]); end
            if (dcyc[1] !== 51) begin errors++; $display("FAIL b2b_done1: got %0d want 51", dcyc[1]); end
            if (dcyc[2] !== 77) begin errors++; $display("FAIL b2b_done2: got %0d want 77", dcyc[2]); end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data_a = 16'h0;
        bus.data_b = 16'h0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
